// File: rtl/layer_composer_ctrl_pkg.sv
// Shared definitions for the pixel composer sequencing logic: state encoding,
// default raster size and counter width helpers.
package vpu_compose_pkg;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_REQ        = 2'd1,
    ST_WAIT_FETCH = 2'd2,
    ST_COMPOSE    = 2'd3
  } state_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  function automatic int xw(input int h_active);
    return (h_active > 1) ? $clog2(h_active) : 1;
  endfunction

  function automatic int yw(input int v_active);
    return (v_active > 1) ? $clog2(v_active) : 1;
  endfunction

endpackage

// File: rtl/layer_composer_ctrl_raster_counter.sv
// Raster position counter: x wraps at end of line and bumps y, last flags the
// final pixel of the frame, clr returns to the origin.
module raster_counter
  import vpu_compose_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int XW       = xw(H_ACTIVE),
  parameter int YW       = yw(V_ACTIVE)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          adv,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          x_end, y_end;

  assign x_end = (x_q == XW'(H_ACTIVE - 1));
  assign y_end = (y_q == YW'(V_ACTIVE - 1));

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clr) begin
      x_d = '0;
      y_d = '0;
    end else if (adv) begin
      if (x_end) begin
        x_d = '0;
        y_d = y_end ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = x_end & y_end;

endmodule

// File: rtl/layer_composer_ctrl.sv
// Per-pixel sequencer: BG pop, parallel sprite-layer fetch, compose commit.
// Optional fetch watchdog under LAYER_COMPOSER_FETCH_TIMEOUT_EN.
module layer_composer_ctrl
  import vpu_compose_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int N_LAYERS = 2
`ifdef LAYER_COMPOSER_FETCH_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        frame_start,
  input  logic                        sprites_ready,
  input  logic                        bg_valid,
  output logic                        bg_rdreq,
  input  logic [N_LAYERS-1:0]         layer_en,
  output logic [N_LAYERS-1:0]         fetch_start,
  input  logic [N_LAYERS-1:0]         fetch_done,
  output logic [N_LAYERS-1:0]         layer_ok,
  input  logic                        wrfull,
  output logic                        pc_enable,
  output logic                        wrreq,
  output logic [xw(H_ACTIVE)-1:0]     pixel_x,
  output logic [yw(V_ACTIVE)-1:0]     pixel_y,
  output logic                        frame_done,
  output logic                        busy
`ifdef LAYER_COMPOSER_FETCH_TIMEOUT_EN
  , output logic                      fetch_timeout
`endif
);

  state_e                state_q, state_d;
  logic [N_LAYERS-1:0]   active_q, active_d;
  logic [N_LAYERS-1:0]   done_q, done_d;
  logic [N_LAYERS-1:0]   layer_ok_q, layer_ok_d;
  logic                  resync_q, resync_d;
  logic [N_LAYERS-1:0]   hit;
  logic                  r_clr, r_adv, r_last;

`ifdef LAYER_COMPOSER_FETCH_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          to_q, to_d;
`endif

  raster_counter #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_raster (
    .clk  (clk),
    .rst  (rst),
    .clr  (r_clr),
    .adv  (r_adv),
    .x    (pixel_x),
    .y    (pixel_y),
    .last (r_last)
  );

  // Lanes that were not launched this pixel can never complete it.
  assign hit = done_q | (fetch_done & active_q);

  always_comb begin
    state_d     = state_q;
    active_d    = active_q;
    done_d      = done_q;
    layer_ok_d  = '0;
    resync_d    = resync_q;
    bg_rdreq    = 1'b0;
    fetch_start = '0;
    pc_enable   = 1'b0;
    wrreq       = 1'b0;
    frame_done  = 1'b0;
    r_clr       = 1'b0;
    r_adv       = 1'b0;
`ifdef LAYER_COMPOSER_FETCH_TIMEOUT_EN
    tmr_d       = tmr_q;
    to_d        = to_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (frame_start || sprites_ready) state_d = ST_REQ;
        if (frame_start) r_clr = 1'b1;
      end
      ST_REQ: begin
        if (!wrfull && bg_valid) begin
          bg_rdreq    = 1'b1;
          fetch_start = layer_en;
          active_d    = layer_en;
          done_d      = '0;
          state_d     = (layer_en == '0) ? ST_COMPOSE : ST_WAIT_FETCH;
`ifdef LAYER_COMPOSER_FETCH_TIMEOUT_EN
          tmr_d       = TW'(TIMEOUT_CYCLES - 1);
`endif
        end
      end
      ST_WAIT_FETCH: begin
        done_d = hit;
        if (hit == active_q) begin
          state_d    = ST_COMPOSE;
          layer_ok_d = hit;
        end
`ifdef LAYER_COMPOSER_FETCH_TIMEOUT_EN
        else if (tmr_q == '0) begin
          state_d    = ST_COMPOSE;
          layer_ok_d = hit;
          to_d       = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
`endif
      end
      ST_COMPOSE: begin
        layer_ok_d = layer_ok_q;
        if (!wrfull) begin
          pc_enable  = 1'b1;
          wrreq      = 1'b1;
          layer_ok_d = '0;
          state_d    = ST_REQ;
          // A pending resync restarts the raster but never drops to IDLE.
          if (resync_q) begin
            r_clr      = 1'b1;
            resync_d   = 1'b0;
            frame_done = r_last;
          end else begin
            r_adv = 1'b1;
            if (r_last) begin
              frame_done = 1'b1;
              state_d    = ST_IDLE;
            end
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (frame_start && (state_q != ST_IDLE)) resync_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      active_q   <= '0;
      done_q     <= '0;
      layer_ok_q <= '0;
      resync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      active_q   <= active_d;
      done_q     <= done_d;
      layer_ok_q <= layer_ok_d;
      resync_q   <= resync_d;
    end
  end

`ifdef LAYER_COMPOSER_FETCH_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr_q <= '0;
      to_q  <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      to_q  <= to_d;
    end
  end

  assign fetch_timeout = to_q;
`endif

  assign layer_ok = layer_ok_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_layer_composer_ctrl.sv
// Directed bench for layer_composer_ctrl on a 4x2 raster with two layers.
module tb_layer_composer_ctrl;

  localparam int H = 4;
  localparam int V = 2;
  localparam int N = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         frame_start;
  logic         sprites_ready;
  logic         bg_valid;
  logic         bg_rdreq;
  logic [N-1:0] layer_en;
  logic [N-1:0] fetch_start;
  logic [N-1:0] fetch_done;
  logic [N-1:0] layer_ok;
  logic         wrfull;
  logic         pc_enable;
  logic         wrreq;
  logic [1:0]   pixel_x;
  logic         pixel_y;
  logic         frame_done;
  logic         busy;
`ifdef LAYER_COMPOSER_FETCH_TIMEOUT_EN
  logic         fetch_timeout;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  layer_composer_ctrl #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .N_LAYERS (N)
`ifdef LAYER_COMPOSER_FETCH_TIMEOUT_EN
    , .TIMEOUT_CYCLES (8)
`endif
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .frame_start   (frame_start),
    .sprites_ready (sprites_ready),
    .bg_valid      (bg_valid),
    .bg_rdreq      (bg_rdreq),
    .layer_en      (layer_en),
    .fetch_start   (fetch_start),
    .fetch_done    (fetch_done),
    .layer_ok      (layer_ok),
    .wrfull        (wrfull),
    .pc_enable     (pc_enable),
    .wrreq         (wrreq),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .frame_done    (frame_done),
    .busy          (busy)
`ifdef LAYER_COMPOSER_FETCH_TIMEOUT_EN
    , .fetch_timeout (fetch_timeout)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; frame_start = 1'b0; sprites_ready = 1'b0; bg_valid = 1'b0;
    layer_en = '0; fetch_done = '0; wrfull = 1'b0;
    tick(); tick();
    #1;
    chk("rst_busy",     32'(busy),        32'd0);
    chk("rst_x",        32'(pixel_x),     32'd0);
    chk("rst_y",        32'(pixel_y),     32'd0);
    chk("rst_layer_ok", 32'(layer_ok),    32'd0);
    chk("rst_wrreq",    32'(wrreq),       32'd0);
    chk("rst_rdreq",    32'(bg_rdreq),    32'd0);
    chk("rst_fstart",   32'(fetch_start), 32'd0);
    chk("rst_fdone",    32'(frame_done),  32'd0);

    // Pixel (0,0), both layers, done lanes at +1 and +3
    rst = 1'b0; layer_en = 2'b11; bg_valid = 1'b1; frame_start = 1'b1;
    #1;
    chk("idle_rdreq", 32'(bg_rdreq), 32'd0);
    chk("idle_busy",  32'(busy),     32'd0);
    tick(); frame_start = 1'b0; fetch_done = 2'b11;
    #1;
    chk("req_rdreq",  32'(bg_rdreq),    32'd1);
    chk("req_fstart", 32'(fetch_start), 32'd3);
    chk("req_busy",   32'(busy),        32'd1);
    tick(); fetch_done = 2'b01;
    #1;
    chk("w1_wrreq", 32'(wrreq), 32'd0);
    tick(); fetch_done = 2'b00;
    #1;
    chk("w2_wrreq",    32'(wrreq),    32'd0);
    chk("w2_layer_ok", 32'(layer_ok), 32'd0);
    tick(); fetch_done = 2'b10;
    #1;
    chk("w3_wrreq", 32'(wrreq), 32'd0);
    tick(); fetch_done = 2'b00;
    #1;
    chk("c0_wrreq",    32'(wrreq),     32'd1);
    chk("c0_pcen",     32'(pc_enable), 32'd1);
    chk("c0_layer_ok", 32'(layer_ok),  32'd3);
    chk("c0_x",        32'(pixel_x),   32'd0);

    // Pixel (1,0) with no layers: REQ then COMPOSE directly
    tick(); layer_en = 2'b00;
    #1;
    chk("p1_x",        32'(pixel_x),     32'd1);
    chk("p1_layer_ok", 32'(layer_ok),    32'd0);
    chk("p1_rdreq",    32'(bg_rdreq),    32'd1);
    chk("p1_fstart",   32'(fetch_start), 32'd0);
    tick();
    #1;
    chk("p1c_wrreq",    32'(wrreq),    32'd1);
    chk("p1c_layer_ok", 32'(layer_ok), 32'd0);

    // Pixel (2,0): stall in REQ, then in COMPOSE with a mid-frame resync
    tick(); wrfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stq_rdreq", 32'(bg_rdreq), 32'd0);
      chk("stq_x",     32'(pixel_x),  32'd2);
      tick();
    end
    wrfull = 1'b0;
    #1;
    chk("relq_rdreq", 32'(bg_rdreq), 32'd1);
    tick(); wrfull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      frame_start = (k == 2);
      #1;
      chk("stc_wrreq", 32'(wrreq),     32'd0);
      chk("stc_pcen",  32'(pc_enable), 32'd0);
      chk("stc_x",     32'(pixel_x),   32'd2);
      tick();
    end
    frame_start = 1'b0; wrfull = 1'b0;
    #1;
    chk("rs_wrreq", 32'(wrreq),      32'd1);
    chk("rs_fdone", 32'(frame_done), 32'd0);
    chk("rs_x",     32'(pixel_x),    32'd2);
    tick();
    #1;
    chk("rs_x0",    32'(pixel_x),  32'd0);
    chk("rs_y0",    32'(pixel_y),  32'd0);
    chk("rs_rdreq", 32'(bg_rdreq), 32'd1);

    // Full frame, one pixel per two cycles
    for (int i = 0; i < H * V; i++) begin
      chk("fr_rdreq", 32'(bg_rdreq), 32'd1);
      tick();
      #1;
      chk("fr_wrreq", 32'(wrreq),      32'd1);
      chk("fr_x",     32'(pixel_x),    32'(i % H));
      chk("fr_y",     32'(pixel_y),    32'(i / H));
      chk("fr_fdone", 32'(frame_done), 32'(i == H * V - 1));
      tick();
      #1;
    end
    chk("end_busy", 32'(busy),    32'd0);
    chk("end_x",    32'(pixel_x), 32'd0);
    chk("end_y",    32'(pixel_y), 32'd0);

    // Reset while WAIT_FETCH holds a partial done mask
    layer_en = 2'b11; sprites_ready = 1'b1;
    tick(); sprites_ready = 1'b0;
    #1;
    chk("r_rdreq", 32'(bg_rdreq), 32'd1);
    tick(); fetch_done = 2'b01;
    #1;
    chk("rw_busy", 32'(busy), 32'd1);
    tick(); fetch_done = 2'b00; rst = 1'b1;
    tick(); rst = 1'b0;
    #1;
    chk("rr_busy",     32'(busy),        32'd0);
    chk("rr_layer_ok", 32'(layer_ok),    32'd0);
    chk("rr_x",        32'(pixel_x),     32'd0);
    chk("rr_fstart",   32'(fetch_start), 32'd0);
    chk("rr_rdreq",    32'(bg_rdreq),    32'd0);
    fetch_done = 2'b10;
    tick(); fetch_done = 2'b00;
    #1;
    chk("rs2_busy", 32'(busy), 32'd0);

    // Restart: one lane done is not enough
    sprites_ready = 1'b1;
    tick(); sprites_ready = 1'b0;
    tick(); fetch_done = 2'b10;
    tick(); fetch_done = 2'b00;
    #1;
    chk("pd_wrreq", 32'(wrreq), 32'd0);
    tick(); fetch_done = 2'b01;
    tick(); fetch_done = 2'b00;
    #1;
    chk("pd_c_wrreq",    32'(wrreq),    32'd1);
    chk("pd_c_layer_ok", 32'(layer_ok), 32'd3);
    chk("pd_c_x",        32'(pixel_x),  32'd0);
    tick();
    #1;
    chk("pd_next_x", 32'(pixel_x), 32'd1);

`ifdef LAYER_COMPOSER_FETCH_TIMEOUT_EN
    // Layer 1 never completes: watchdog forces COMPOSE after 8 cycles
    chk("to_idle_flag", 32'(fetch_timeout), 32'd0);
    tick(); fetch_done = 2'b01;
    #1;
    chk("to_w1_wrreq", 32'(wrreq), 32'd0);
    tick(); fetch_done = 2'b00;
    for (int k = 0; k < 7; k++) begin
      #1;
      chk("to_w_wrreq", 32'(wrreq), 32'd0);
      tick();
    end
    #1;
    chk("to_c_wrreq",    32'(wrreq),         32'd1);
    chk("to_c_layer_ok", 32'(layer_ok),      32'd1);
    chk("to_c_flag",     32'(fetch_timeout), 32'd1);
    tick();
    #1;
    chk("to_sticky", 32'(fetch_timeout), 32'd1);
    rst = 1'b1;
    tick(); rst = 1'b0;
    #1;
    chk("to_rst", 32'(fetch_timeout), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_composer_ctrl.md
Name: layer_composer_ctrl

Overview:
Per-pixel sequencing controller for the pixel composer: pops one background word, launches N parallel sprite-layer fetches, waits for all enabled layers, then commits one composed pixel to the output FIFO. Generalises the single-layer composer controller with parametrised resolution and layer count, internal raster counters, per-layer enable, a deferred mid-frame resync, and an end-of-frame pulse. Sits between the BG FIFO, the sprite_pixel_fetcher instances and the pixel_composer output FIFO, all on clk.

Parameters:
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
N_LAYERS, 2, number of sprite-layer fetch channels (1..8)
TIMEOUT_CYCLES, 64, WAIT_FETCH watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock (clk_sys)
rst  in  1  synchronous reset, active-high
frame_start  in  1  pulse: start of frame
sprites_ready  in  1  level: sprite tables loaded; allows start from IDLE
bg_valid  in  1  BG FIFO has data
bg_rdreq  out  1  BG FIFO pop, 1-cycle pulse
layer_en  in  N_LAYERS  per-layer enable, sampled at fetch launch
fetch_start  out  N_LAYERS  per-layer start pulse
fetch_done  in  N_LAYERS  per-layer done pulse
layer_ok  out  N_LAYERS  layers valid for the current compose; held through COMPOSE
wrfull  in  1  output FIFO full
pc_enable  out  1  composer advance strobe
wrreq  out  1  output FIFO write
pixel_x  out  $clog2(H_ACTIVE)  current pixel column
pixel_y  out  $clog2(V_ACTIVE)  current pixel row
frame_done  out  1  pulse on commit of last pixel
busy  out  1  high whenever state != IDLE

Behaviour:
- Reset (sync, rst=1 at posedge): state=IDLE; pixel_x=pixel_y=0; active/done masks=0; resync flag=0; every output 0.
- bg_rdreq, fetch_start, pc_enable, wrreq and frame_done are combinational from state and inputs, single-cycle. Other outputs are registered.
- IDLE: if frame_start or sprites_ready, go to REQ. frame_start also zeroes x and y.
- REQ: waits while wrfull=1 or bg_valid=0, with no pulses. Otherwise, in one cycle: bg_rdreq=1; fetch_start=layer_en; active<=layer_en; done<=0.
  - Next state is WAIT_FETCH.
  - If layer_en==0, next state is COMPOSE directly. Minimum pixel time is 2 cycles.
- WAIT_FETCH: done <= done | (fetch_done & active). fetch_done on non-active lanes is ignored. When (done | (fetch_done & active)) == active, go to COMPOSE and register layer_ok from that value. A fetch_done coincident with fetch_start (the REQ cycle) is ignored.
- COMPOSE: stall while wrfull=1; layer_ok is held. Once wrfull=0: pc_enable=1, wrreq=1, then advance the raster.
  - x==H_ACTIVE-1: x wraps to 0 and y increments.
  - Last pixel (x==H_ACTIVE-1, y==V_ACTIVE-1): frame_done=1, x=y=0, next state IDLE.
  - Otherwise next state REQ.
- Mid-frame frame_start (state != IDLE) sets the sticky resync flag and is not acted on immediately. At the next COMPOSE commit the flag clears, x=y=0, next state REQ, and frame_done is not pulsed. If the commit is also the last pixel, frame_done pulses and the next state is REQ, not IDLE.
- frame_start in IDLE coincident with rst: rst wins.
- layer_ok=0 outside COMPOSE.

Optional Feature:
Macro LAYER_COMPOSER_FETCH_TIMEOUT_EN.
- With the macro: a counter runs in WAIT_FETCH. After TIMEOUT_CYCLES cycles without completion, the block forces COMPOSE with layer_ok=done, so missing layers read as 0 and the BG-only pixel still commits. The extra output port fetch_timeout (1 bit) is set sticky and is cleared only by rst. The counter clears on every entry to WAIT_FETCH.
- Without the macro: no counter, no fetch_timeout port, WAIT_FETCH can wait indefinitely.

Decomposition:
- Package vpu_compose_pkg holds the state encoding (IDLE=0, REQ=1, WAIT_FETCH=2, COMPOSE=3), the default H_ACTIVE/V_ACTIVE, and the XW/YW width functions.
- One natural sub-module, raster_counter: x/y counter with wrap, last-pixel flag and sync clear, instantiated once.

Test Plan:
- 640x480, N=2, layer_en=2'b11, done lanes at +1 and +3 cycles → COMPOSE entered only after the second done; layer_ok=2'b11; wrreq once per pixel; 307200 wrreq per frame; frame_done exactly once, on the cycle x=639, y=479 is written.
- layer_en=0, bg_valid=1, wrfull=0 → REQ/COMPOSE alternate; one pixel every 2 cycles; fetch_start never asserted.
- Hold wrfull=1 for 5 cycles during REQ and then during COMPOSE → no bg_rdreq/wrreq/pc_enable; x, y and layer_ok stable; exactly one write after release.
- H_ACTIVE=4, V_ACTIVE=2, frame_start pulse at pixel (2,0) → pixel (2,0) completes, next write is (0,0), no frame_done for the aborted frame.
- Assert rst in WAIT_FETCH with done partially set → next cycle IDLE, all outputs 0, x=y=0; a stale fetch_done after reset causes no transition.
- With LAYER_COMPOSER_FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=8, layer 1 never done → COMPOSE after 8 cycles in WAIT_FETCH; layer_ok=2'b01; fetch_timeout=1 and stays 1 until rst.
